// File: rtl/stopwatch_ctrl.sv
// Single-button stopwatch controller: synchronises and debounces the button,
// steps IDLE -> RUN -> STOP -> IDLE on each press, and generates the 10 ms count strobe.
module stopwatch_ctrl #(
    parameter logic sim = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic ButtonIn,
    output logic press,
    output logic count_en,
    output logic count_clr,
    output logic tick_10ms,
    output logic led0,
    output logic led1,
    output logic led2
);

    localparam int unsigned DB_CYCLES   = sim ? 32'd16 : 32'd1_000_000;
    localparam int unsigned TICK_CYCLES = sim ? 32'd10 : 32'd500_000;
    localparam int unsigned DB_W        = 20;
    localparam int unsigned PS_W        = 19;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    logic            s1;
    logic            s2;
    logic            db;
    logic            db_q;
    logic            fall_q;
    logic [DB_W-1:0] db_cnt;
    logic [PS_W-1:0] presc;
    state_t          state;
    state_t          state_nxt;

    // Two-flop synchroniser, debounce counter and press pulse generation
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1     <= 1'b1;
            s2     <= 1'b1;
            db     <= 1'b1;
            db_q   <= 1'b1;
            fall_q <= 1'b0;
            db_cnt <= '0;
            press  <= 1'b0;
        end else begin
            s1     <= ButtonIn;
            s2     <= s1;
            db_q   <= db;
            fall_q <= db_q & ~db;
            press  <= fall_q;
            if (s2 == db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_W'(DB_CYCLES - 1)) begin
                db     <= ~db;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    // Next state: advance only on a press
    always_comb begin
        state_nxt = state;
        if (press) begin
            case (state)
                IDLE:    state_nxt = RUN;
                RUN:     state_nxt = STOP;
                STOP:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State, prescaler and registered decode of the outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            presc     <= '0;
            tick_10ms <= 1'b0;
            count_en  <= 1'b0;
            count_clr <= 1'b1;
            led0      <= 1'b1;
            led1      <= 1'b0;
            led2      <= 1'b0;
        end else begin
            state     <= state_nxt;
            count_en  <= (state_nxt == RUN);
            count_clr <= (state_nxt == IDLE);
            led0      <= (state_nxt == IDLE);
            led1      <= (state_nxt == RUN);
            led2      <= (state_nxt == STOP);
            tick_10ms <= 1'b0;
            case (state)
                RUN: begin
                    if (presc == PS_W'(TICK_CYCLES - 1)) begin
                        presc     <= '0;
                        tick_10ms <= 1'b1;
                    end else begin
                        presc <= presc + PS_W'(1);
                    end
                end
                STOP:    presc <= presc;
                default: presc <= '0;
            endcase
        end
    end

endmodule
